// File: rtl/io_uart_tx_engine_pkg.sv
// UART definitions shared by the transmitter and the future receiver:
// FSM state codes, data-length encoding and small frame helpers.
package io_uart_tx_engine_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [1:0] BITS_5 = 2'b00;
  localparam logic [1:0] BITS_6 = 2'b01;
  localparam logic [1:0] BITS_7 = 2'b10;
  localparam logic [1:0] BITS_8 = 2'b11;

  localparam int unsigned BITS_BASE = 5;

  // Index of the last data bit sent for a given length code (4..7).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] bits);
    return 3'(BITS_BASE - 1) + {1'b0, bits};
  endfunction

  // Even parity over only the bits that will actually be transmitted.
  function automatic logic even_parity(input logic [7:0] data, input logic [1:0] bits);
    logic [7:0] mask;
    mask = 8'hFF >> (BITS_8 - bits);
    return ^(data & mask);
  endfunction

endpackage

// File: rtl/io_uart_tx_engine_baud_cnt.sv
// Baud-period counter: counts 0..div_i and pulses tick_o on the last cycle
// of each bit period. Shared with the receiver.
module io_uart_baud_cnt #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;

  assign tick_o = (cnt_q == div_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/io_uart_tx_engine.sv
// UART transmit serialiser: pops a byte from the TX FIFO and shifts out
// start, 5-8 data bits LSB first, optional even parity and 1-2 stop bits.
module io_uart_tx_engine
  import io_uart_tx_engine_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [1:0]           cfg_bits_i,
  input  logic                 cfg_parity_en_i,
  input  logic                 cfg_stop_bits_i,
  input  logic [7:0]           tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  logic [2:0]           state_q;
  logic                 tx_q;
  logic [7:0]           shift_q;
  logic [2:0]           bit_cnt_q;
  logic                 stop_cnt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [1:0]           bits_q;
  logic                 par_en_q;
  logic                 stop2_q;
  logic                 par_q;
  logic                 tick;
  logic                 accept;

  // Ready is forced low while reset is held so the FIFO never pops into a dead engine.
  assign tx_ready_o = rstn_i && (state_q == ST_IDLE) && cfg_en_i;
  assign accept     = tx_ready_o && tx_valid_i;
  assign busy_o     = (state_q != ST_IDLE);
  assign tx_o       = tx_q;

  io_uart_baud_cnt #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (state_q == ST_IDLE),
    .div_i  (div_q),
    .tick_o (tick)
  );

  // tx_q is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state and stays glitch-free.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      div_q      <= '0;
      bits_q     <= BITS_5;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q   <= ST_START;
            tx_q      <= 1'b0;
            shift_q   <= tx_data_i;
            bit_cnt_q <= '0;
            div_q     <= cfg_div_i;
            bits_q    <= cfg_bits_i;
            par_en_q  <= cfg_parity_en_i;
            stop2_q   <= cfg_stop_bits_i;
            par_q     <= even_parity(tx_data_i, cfg_bits_i);
          end
        end
        ST_START: begin
          if (tick) begin
            state_q   <= ST_DATA;
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt_q == last_bit_idx(bits_q)) begin
              if (par_en_q) begin
                state_q <= ST_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q    <= ST_STOP;
                tx_q       <= 1'b1;
                stop_cnt_q <= 1'b0;
              end
            end else begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_q    <= ST_STOP;
            tx_q       <= 1'b1;
            stop_cnt_q <= 1'b0;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop_cnt_q == stop2_q) begin
              state_q <= ST_IDLE;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
